// File: rtl/comb_prim_sched.sv
// Round-robin sequencer for a single shared comb evaluator (Y = ~A & B & C & ~D),
// with a self-test sweep that builds the evaluator's truth table and checks it.
module udp_comb (
  output logic y,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d
);
  assign y = ~a & b & c & ~d;
endmodule

module comb_prim_sched #(
  parameter logic [15:0] GOLDEN     = 16'h0040,
  parameter bit          FIRST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [3:0]  din0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [3:0]  din1,
  output logic        gnt1,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_y,
  input  logic        scan_start,
  output logic        scan_busy,
  output logic        scan_done,
  output logic        scan_pass,
  output logic [15:0] truth_tbl
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_SCAN} state_t;

  state_t      r_state;
  logic [3:0]  r_op;
  logic [3:0]  r_cnt;
  logic        r_win;
  logic        r_last;

  logic [3:0]  w_eval_in;
  logic        w_y;
  logic        w_any;
  logic        w_pick1;

  // The evaluator is shared: the sweep counter drives it only while scanning,
  // so a grant made just before scan entry still sees its own operand.
  assign w_eval_in = (r_state == S_SCAN) ? r_cnt : r_op;
  assign w_any     = req0 | req1;
  assign w_pick1   = req1 & (~req0 | ~r_last);

  udp_comb u_eval (
    .y (w_y),
    .a (w_eval_in[3]),
    .b (w_eval_in[2]),
    .c (w_eval_in[1]),
    .d (w_eval_in[0])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_cnt     <= '0;
      r_win     <= 1'b0;
      r_last    <= ~FIRST_PRIO;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= 1'b0;
      scan_busy <= 1'b0;
      scan_done <= 1'b0;
      scan_pass <= 1'b0;
      truth_tbl <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      scan_done <= 1'b0;
      rsp_valid <= (r_state == S_SERVE);
      if (r_state == S_SERVE) begin
        rsp_id <= r_win;
        rsp_y  <= w_y;
      end
      case (r_state)
        S_SCAN: begin
          truth_tbl[r_cnt] <= w_y;
          r_cnt            <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            scan_busy <= 1'b0;
            scan_done <= 1'b1;
            scan_pass <= ({w_y, truth_tbl[14:0]} == GOLDEN);
            r_state   <= S_IDLE;
          end
        end
        default: begin
          if (scan_start) begin
            scan_busy <= 1'b1;
            scan_pass <= 1'b0;
            truth_tbl <= '0;
            r_cnt     <= '0;
            r_state   <= S_SCAN;
          end else if (w_any) begin
            gnt0    <= ~w_pick1;
            gnt1    <= w_pick1;
            r_win   <= w_pick1;
            r_last  <= w_pick1;
            r_op    <= w_pick1 ? din1 : din0;
            r_state <= S_SERVE;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comb_prim_sched.sv
// Directed and random bench for comb_prim_sched against a transaction-level model.
module tb_comb_prim_sched;

  localparam logic [15:0] GOLD = 16'h0040;
  localparam bit          FP   = 1'b0;

  logic        clk = 1'b0;
  logic        rst, req0, req1, scan_start;
  logic [3:0]  din0, din1;
  logic        gnt0, gnt1, rsp_valid, rsp_id, rsp_y;
  logic        scan_busy, scan_done, scan_pass;
  logic [15:0] truth_tbl;

  comb_prim_sched #(.GOLDEN(GOLD), .FIRST_PRIO(FP)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .gnt0(gnt0),
    .req1(req1), .din1(din1), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
    .scan_pass(scan_pass), .truth_tbl(truth_tbl)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: pending response, last winner, sweep progress.
  bit          m_pend, m_pend_id, m_last, m_scanning;
  logic [3:0]  m_pend_op;
  int          m_scan_idx;
  logic        e_gnt0, e_gnt1, e_rv, e_id, e_y, e_busy, e_done, e_pass;
  logic [15:0] e_tbl;

  function automatic logic f(input logic [3:0] x);
    return (x == 4'b0110);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit w;
    if (rst) begin
      {e_gnt0, e_gnt1, e_rv, e_id, e_y, e_busy, e_done, e_pass} = '0;
      e_tbl = '0; m_pend = 0; m_scanning = 0; m_scan_idx = 0; m_last = ~FP;
      return;
    end
    e_rv = m_pend;
    if (m_pend) begin e_id = m_pend_id; e_y = f(m_pend_op); end
    m_pend = 0; e_gnt0 = 0; e_gnt1 = 0; e_done = 0;
    if (m_scanning) begin
      m_scan_idx++;
      e_tbl = '0;
      for (int unsigned i = 0; i < 16; i++)
        if (int'(i) < m_scan_idx) e_tbl[i] = f(4'(i));
      if (m_scan_idx == 16) begin
        m_scanning = 0; e_done = 1; e_pass = (e_tbl == GOLD);
      end
    end else if (scan_start) begin
      m_scanning = 1; m_scan_idx = 0; e_tbl = '0; e_pass = 0;
    end else if (req0 || req1) begin
      w = (req0 && req1) ? ~m_last : req1;
      m_last = w; m_pend = 1; m_pend_id = w;
      m_pend_op = w ? din1 : din0;
      e_gnt0 = ~w; e_gnt1 = w;
    end
    e_busy = m_scanning;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    chk("gnt0", 16'(gnt0), 16'(e_gnt0));
    chk("gnt1", 16'(gnt1), 16'(e_gnt1));
    chk("rsp_valid", 16'(rsp_valid), 16'(e_rv));
    chk("rsp_id", 16'(rsp_id), 16'(e_id));
    chk("rsp_y", 16'(rsp_y), 16'(e_y));
    chk("scan_busy", 16'(scan_busy), 16'(e_busy));
    chk("scan_done", 16'(scan_done), 16'(e_done));
    chk("scan_pass", 16'(scan_pass), 16'(e_pass));
    chk("truth_tbl", truth_tbl, e_tbl);
  endtask

  task automatic idle_in();
    rst = 0; req0 = 0; req1 = 0; scan_start = 0; din0 = '0; din1 = '0;
  endtask

  initial begin
    idle_in(); rst = 1;
    step(); step();
    rst = 0;

    // single request with the one operand that evaluates true
    req0 = 1; din0 = 4'b0110; step();
    chk("single_gnt0", 16'(gnt0), 16'd1);
    req0 = 0; step();
    chk("single_rsp", {13'd0, rsp_valid, rsp_id, rsp_y}, 16'b101);

    // contested arbitration from a fresh reset
    rst = 1; step(); rst = 0;
    req0 = 1; req1 = 1; din0 = 4'b0110; din1 = 4'b1110;
    step();
    chk("first_prio", 16'(gnt1), 16'(FP));
    repeat (6) step();
    idle_in(); step(); step();

    // lone requester, back-to-back grants
    req1 = 1;
    din1 = 4'd5; step(); din1 = 4'd6; step();
    din1 = 4'd7; step(); din1 = 4'd6; step();
    idle_in(); step(); step();

    // full sweep from idle
    scan_start = 1; step(); scan_start = 0;
    repeat (16) step();
    chk("sweep_tbl", truth_tbl, 16'h0040);
    chk("sweep_pass", 16'(scan_pass), 16'd1);
    repeat (3) step();

    // scan beats a simultaneous request; re-start during busy ignored
    req0 = 1; din0 = 4'b0110; scan_start = 1; step(); scan_start = 0;
    repeat (4) step();
    scan_start = 1; step(); scan_start = 0;
    repeat (11) step();
    chk("held_done", 16'(scan_done), 16'd1);
    step();
    chk("held_gnt0", 16'(gnt0), 16'd1);
    req0 = 0; step(); step();

    // reset mid-sweep discards the partial table
    scan_start = 1; step(); scan_start = 0;
    repeat (8) step();
    rst = 1; step(); rst = 0;
    chk("rst_tbl", truth_tbl, 16'h0000);
    repeat (12) step();

    // reset with a grant in flight suppresses the response
    req1 = 1; din1 = 4'b0110; step(); req1 = 0;
    rst = 1; step(); rst = 0;
    chk("rst_no_rsp", 16'(rsp_valid), 16'd0);
    step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      req0 = 1'($urandom); req1 = 1'($urandom);
      din0 = 4'($urandom); din1 = 4'($urandom);
      scan_start = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
